// File: rtl/ps2_voice_allocator_pkg.sv
// Shared types and constants for the PS/2 voice allocator.
// Scancode note table: C4..B5, Q24.8 Hz.
package ps2_voice_allocator_pkg;

  localparam int VOICES = 8;
  localparam int IDX_W  = $clog2(VOICES);
  localparam int VOL_W  = 16;
  localparam int FREQ_W = 32;
  localparam int NOTES  = 24;

  typedef enum logic [1:0] {
    V_IDLE,
    V_ATTACK,
    V_SUSTAIN,
    V_RELEASE
  } voice_state_t;

  typedef enum logic [1:0] {
    E_WAIT,
    E_DECODE,
    E_APPLY
  } evt_state_t;

  typedef struct packed {
    logic              valid;
    logic [FREQ_W-1:0] freq;
  } note_t;

  localparam logic [7:0] NOTE_CODE [NOTES] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
    8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
    8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D,
    8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C
  };

  localparam logic [FREQ_W-1:0] NOTE_FREQ [NOTES] = '{
    32'd66977,  32'd70959,  32'd75178,  32'd79649,
    32'd84385,  32'd89402,  32'd94719,  32'd100351,
    32'd106318, 32'd112640, 32'd119338, 32'd126434,
    32'd133952, 32'd141918, 32'd150356, 32'd159297,
    32'd168769, 32'd178805, 32'd189437, 32'd200702,
    32'd212636, 32'd225280, 32'd238676, 32'd252868
  };

  function automatic note_t note_lookup(input logic [7:0] code);
    note_t n;
    n = '0;
    for (int i = 0; i < NOTES; i++) begin
      if (NOTE_CODE[i] == code) begin
        n.valid = 1'b1;
        n.freq  = NOTE_FREQ[i];
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ps2_voice_allocator_if.sv
// Key event in, per-voice frequency/volume arrays out.
// master = key source / synth side, slave = allocator.
interface ps2_voice_allocator_if;
  import ps2_voice_allocator_pkg::*;

  logic [10:0]       ps2_key;
  logic [FREQ_W-1:0] frequencies   [VOICES];
  logic [31:0]       voice_volumes [VOICES];

  modport master (
    output ps2_key,
    input  frequencies,
    input  voice_volumes
  );

  modport slave (
    input  ps2_key,
    output frequencies,
    output voice_volumes
  );
endinterface

// File: rtl/ps2_voice_allocator_note_rom.sv
// Registered scancode -> note frequency lookup.
// One cycle from code to {valid, freq}.
module ps2_note_rom
  import ps2_voice_allocator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_code,
  output note_t      o_note
);

  note_t r_note;

  // register the table lookup
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_note <= '0;
    else       r_note <= note_lookup(i_code);
  end

  assign o_note = r_note;

endmodule

// File: rtl/ps2_voice_allocator.sv
// PS/2 key events -> voice allocation + linear ASR envelopes.
// Toggle is synchronised; payload is read once the toggle is seen.
module ps2_voice_allocator
  import ps2_voice_allocator_pkg::*;
#(
  parameter int              ENV_DIV      = 960,
  parameter logic [VOL_W-1:0] ATTACK_STEP = 16'd2048,
  parameter logic [VOL_W-1:0] RELEASE_STEP = 16'd512,
  parameter logic [VOL_W-1:0] VOL_MAX     = 16'hFFFF
) (
  input logic clk,
  input logic reset,
  ps2_voice_allocator_if.slave bus
);

  localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  logic             r_tog_s1;
  logic             r_tog_s2;
  logic             r_tog_ref;
  logic             r_primed;
  logic             r_pressed;
  logic             r_ext;
  logic [7:0]       r_code;
  evt_state_t       r_evt;
  evt_state_t       w_evt_nxt;
  logic             w_toggle;
  logic             w_latch;
  logic             w_apply;
  note_t            w_note;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [IDX_W-1:0] r_rr;
  logic             w_rr_adv;

  voice_state_t     w_st  [VOICES];
  logic [7:0]       w_key [VOICES];

  logic             w_act_hit;
  logic [IDX_W-1:0] w_act_idx;
  logic             w_rel_hit;
  logic [IDX_W-1:0] w_rel_idx;
  logic             w_idle_any;
  logic [IDX_W-1:0] w_idle_idx;
  logic             w_relv_any;
  logic [IDX_W-1:0] w_relv_idx;
  logic             w_ok;
  logic [VOICES-1:0] w_sel_new;
  logic [VOICES-1:0] w_sel_retrig;
  logic [VOICES-1:0] w_sel_rel;

  // toggle synchroniser; free-running so it has settled when reset drops
  always_ff @(posedge clk) begin
    r_tog_s1 <= bus.ps2_key[10];
    r_tog_s2 <= r_tog_s1;
  end

  assign w_toggle = r_primed && (r_tog_s2 != r_tog_ref);

  // prime toggle reference once, then latch the event payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_primed  <= 1'b0;
      r_tog_ref <= 1'b0;
      r_pressed <= 1'b0;
      r_ext     <= 1'b0;
      r_code    <= '0;
    end else if (!r_primed) begin
      r_primed  <= 1'b1;
      r_tog_ref <= r_tog_s2;
    end else if (w_latch) begin
      r_tog_ref <= r_tog_s2;
      r_pressed <= bus.ps2_key[9];
      r_ext     <= bus.ps2_key[8];
      r_code    <= bus.ps2_key[7:0];
    end
  end

  // event FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_evt <= E_WAIT;
    else       r_evt <= w_evt_nxt;
  end

  // event FSM next state and strobes
  always_comb begin
    w_evt_nxt = r_evt;
    w_latch   = 1'b0;
    w_apply   = 1'b0;
    unique case (r_evt)
      E_WAIT: begin
        if (w_toggle) begin
          w_latch   = 1'b1;
          w_evt_nxt = E_DECODE;
        end
      end
      E_DECODE: w_evt_nxt = E_APPLY;
      E_APPLY: begin
        w_apply   = 1'b1;
        w_evt_nxt = E_WAIT;
      end
      default: w_evt_nxt = E_WAIT;
    endcase
  end

  ps2_note_rom u_rom (
    .clk    (clk),
    .reset  (reset),
    .i_code (r_code),
    .o_note (w_note)
  );

  // envelope tick divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  assign w_tick = (r_div == DIV_W'(ENV_DIV - 1));

  // lowest-index searches over the voice bank
  always_comb begin
    w_act_hit  = 1'b0;
    w_act_idx  = '0;
    w_rel_hit  = 1'b0;
    w_rel_idx  = '0;
    w_idle_any = 1'b0;
    w_idle_idx = '0;
    w_relv_any = 1'b0;
    w_relv_idx = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (w_key[v] == r_code &&
          (w_st[v] == V_ATTACK || w_st[v] == V_SUSTAIN)) begin
        w_act_hit = 1'b1;
        w_act_idx = IDX_W'(v);
      end
      if (w_key[v] == r_code && w_st[v] == V_RELEASE) begin
        w_rel_hit = 1'b1;
        w_rel_idx = IDX_W'(v);
      end
      if (w_st[v] == V_IDLE) begin
        w_idle_any = 1'b1;
        w_idle_idx = IDX_W'(v);
      end
      if (w_st[v] == V_RELEASE) begin
        w_relv_any = 1'b1;
        w_relv_idx = IDX_W'(v);
      end
    end
  end

  assign w_ok = w_apply && w_note.valid && !r_ext;

  // choose the voice an applied event acts on
  always_comb begin
    w_sel_new    = '0;
    w_sel_retrig = '0;
    w_sel_rel    = '0;
    w_rr_adv     = 1'b0;
    if (w_ok && r_pressed) begin
      if (w_act_hit) begin
        w_rr_adv = 1'b0;
      end else if (w_rel_hit) begin
        w_sel_retrig[w_rel_idx] = 1'b1;
      end else if (w_idle_any) begin
        w_sel_new[w_idle_idx] = 1'b1;
      end else if (w_relv_any) begin
        w_sel_new[w_relv_idx] = 1'b1;
      end else begin
        w_sel_new[r_rr] = 1'b1;
        w_rr_adv        = 1'b1;
      end
    end else if (w_ok && w_act_hit) begin
      w_sel_rel[w_act_idx] = 1'b1;
    end
  end

  // round-robin steal pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rr <= '0;
    else if (w_rr_adv)
      r_rr <= (r_rr == IDX_W'(VOICES - 1)) ? '0 : r_rr + 1'b1;
  end

  for (genvar gv = 0; gv < VOICES; gv++) begin : g_voice
    voice_state_t      r_st;
    logic [VOL_W-1:0]  r_vol;
    logic [FREQ_W-1:0] r_freq;
    logic [7:0]        r_key;
    logic [VOL_W:0]    w_sum;

    assign w_sum = {1'b0, r_vol} + {1'b0, ATTACK_STEP};

    // event updates override the envelope tick on this voice
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_st   <= V_IDLE;
        r_vol  <= '0;
        r_freq <= '0;
        r_key  <= '0;
      end else if (w_sel_new[gv]) begin
        r_st   <= V_ATTACK;
        r_vol  <= '0;
        r_freq <= w_note.freq;
        r_key  <= r_code;
      end else if (w_sel_retrig[gv]) begin
        r_st <= V_ATTACK;
      end else if (w_sel_rel[gv]) begin
        r_st <= V_RELEASE;
      end else if (w_tick) begin
        unique case (r_st)
          V_ATTACK: begin
            if (w_sum >= {1'b0, VOL_MAX}) begin
              r_vol <= VOL_MAX;
              r_st  <= V_SUSTAIN;
            end else begin
              r_vol <= w_sum[VOL_W-1:0];
            end
          end
          V_RELEASE: begin
            if (r_vol <= RELEASE_STEP) begin
              r_vol  <= '0;
              r_st   <= V_IDLE;
              r_freq <= '0;
              r_key  <= '0;
            end else begin
              r_vol <= r_vol - RELEASE_STEP;
            end
          end
          V_IDLE, V_SUSTAIN: r_st <= r_st;
        endcase
      end
    end

    assign w_st[gv]  = r_st;
    assign w_key[gv] = r_key;
    assign bus.frequencies[gv]   = r_freq;
    assign bus.voice_volumes[gv] = {{(32 - VOL_W){1'b0}}, r_vol};
  end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Bench for ps2_voice_allocator: directed cases plus random
// key traffic against an array-based voice model.
module tb_ps2_voice_allocator;

  localparam int DIV = 20;
  localparam int S_IDLE = 0;
  localparam int S_ATT  = 1;
  localparam int S_SUS  = 2;
  localparam int S_REL  = 3;

  logic clk = 1'b0;
  logic reset;

  ps2_voice_allocator_if u_if();

  ps2_voice_allocator #(.ENV_DIV(DIV)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int m_st   [8];
  int m_vol  [8];
  int m_freq [8];
  int m_key  [8];
  int m_rr;
  int m_div;
  int ev_cnt;
  bit ev_p;
  bit ev_e;
  int ev_code;
  bit in_rst;
  bit tog;

  int codes [24] = '{
    'h1A, 'h1B, 'h22, 'h23, 'h21, 'h2A, 'h34, 'h32, 'h33, 'h31, 'h3B, 'h3A,
    'h15, 'h1E, 'h1D, 'h26, 'h24, 'h2D, 'h2E, 'h2C, 'h36, 'h35, 'h3D, 'h3C
  };
  int freqs [24] = '{
    66977, 70959, 75178, 79649, 84385, 89402,
    94719, 100351, 106318, 112640, 119338, 126434,
    133952, 141918, 150356, 159297, 168769, 178805,
    189437, 200702, 212636, 225280, 238676, 252868
  };

  function automatic int note_freq(int code);
    for (int i = 0; i < 24; i++)
      if (codes[i] == code) return freqs[i];
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < 8; v++) begin
      m_st[v] = S_IDLE;
      m_vol[v] = 0;
      m_freq[v] = 0;
      m_key[v] = 0;
    end
    m_rr = 0;
    m_div = 0;
    ev_cnt = 0;
  endtask

  task automatic model_edge();
    int p_st [8];
    int p_vol [8];
    int p_freq [8];
    int p_key [8];
    bit tick;
    int act;
    int rel;
    int t;
    int f;
    tick = (m_div == DIV - 1);
    m_div = tick ? 0 : m_div + 1;
    p_st = m_st;
    p_vol = m_vol;
    p_freq = m_freq;
    p_key = m_key;
    if (tick) begin
      for (int v = 0; v < 8; v++) begin
        if (m_st[v] == S_ATT) begin
          m_vol[v] = m_vol[v] + 2048;
          if (m_vol[v] >= 65535) begin
            m_vol[v] = 65535;
            m_st[v] = S_SUS;
          end
        end else if (m_st[v] == S_REL) begin
          m_vol[v] = m_vol[v] - 512;
          if (m_vol[v] <= 0) begin
            m_vol[v] = 0;
            m_st[v] = S_IDLE;
            m_freq[v] = 0;
            m_key[v] = 0;
          end
        end
      end
    end
    if (ev_cnt > 0) begin
      ev_cnt--;
      f = note_freq(ev_code);
      if (ev_cnt == 0 && !ev_e && f != 0) begin
        act = -1;
        rel = -1;
        for (int v = 7; v >= 0; v--) begin
          if (p_key[v] == ev_code && (p_st[v] == S_ATT || p_st[v] == S_SUS))
            act = v;
          if (p_key[v] == ev_code && p_st[v] == S_REL)
            rel = v;
        end
        t = -1;
        if (ev_p && act < 0 && rel >= 0) begin
          t = rel;
          m_st[t] = S_ATT;
          m_vol[t] = p_vol[t];
          m_freq[t] = p_freq[t];
          m_key[t] = p_key[t];
        end else if (ev_p && act < 0) begin
          for (int v = 7; v >= 0; v--)
            if (p_st[v] == S_REL) t = v;
          for (int v = 7; v >= 0; v--)
            if (p_st[v] == S_IDLE) t = v;
          if (t < 0) begin
            t = m_rr;
            m_rr = (m_rr + 1) % 8;
          end
          m_st[t] = S_ATT;
          m_vol[t] = 0;
          m_freq[t] = f;
          m_key[t] = ev_code;
        end else if (!ev_p && act >= 0) begin
          m_st[act] = S_REL;
          m_vol[act] = p_vol[act];
          m_freq[act] = p_freq[act];
          m_key[act] = p_key[act];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int v = 0; v < 8; v++) begin
      chk($sformatf("freq[%0d]", v), u_if.frequencies[v], m_freq[v]);
      chk($sformatf("vol[%0d]", v), u_if.voice_volumes[v], m_vol[v]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!in_rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input bit p, input bit e, input int code);
    tog = ~tog;
    u_if.ps2_key = {tog, p, e, 8'(code)};
    ev_p = p;
    ev_e = e;
    ev_code = code;
    ev_cnt = 5;
  endtask

  task automatic hit_reset();
    #2;
    reset = 1'b1;
    in_rst = 1'b1;
    model_clear();
    #1;
    chk("async_rst_freq0", u_if.frequencies[0], 0);
    chk("async_rst_vol0", u_if.voice_volumes[0], 0);
  endtask

  task automatic drop_reset();
    for (int i = 0; i < 4; i++) begin
      u_if.ps2_key = 11'($urandom);
      tog = u_if.ps2_key[10];
      step();
    end
    u_if.ps2_key = {1'b1, 10'($urandom)};
    tog = 1'b1;
    steps(4);
    @(negedge clk);
    reset = 1'b0;
    in_rst = 1'b0;
  endtask

  initial begin
    int c;
    reset = 1'b1;
    in_rst = 1'b1;
    tog = 1'b0;
    u_if.ps2_key = '0;
    ev_p = 1'b0;
    ev_e = 1'b0;
    ev_code = 0;
    model_clear();
    drop_reset();
    steps(6);
    chk("rst_freq7", u_if.frequencies[7], 0);

    send(1, 0, 'h31);
    steps(4);
    chk("lat4_freq0", u_if.frequencies[0], 0);
    steps(1);
    chk("lat5_freq0", u_if.frequencies[0], 112640);
    chk("lat5_vol0", u_if.voice_volumes[0], 0);
    steps(33 * DIV);
    chk("sus_vol0", u_if.voice_volumes[0], 65535);

    send(1, 0, 'h31);
    steps(3 * DIV);
    chk("repeat_vol0", u_if.voice_volumes[0], 65535);
    chk("repeat_freq0", u_if.frequencies[0], 112640);

    send(0, 0, 'h31);
    steps(5 + 129 * DIV);
    chk("rel_freq0", u_if.frequencies[0], 0);
    chk("rel_vol0", u_if.voice_volumes[0], 0);

    for (int i = 0; i < 9; i++) begin
      send(1, 0, codes[i]);
      steps(8);
    end
    chk("steal_freq0", u_if.frequencies[0], 106318);
    chk("fill_freq7", u_if.frequencies[7], 100351);
    send(1, 0, 'h31);
    steps(8);
    chk("rr_freq1", u_if.frequencies[1], 112640);

    send(1, 1, 'h15);
    steps(8);
    send(1, 0, 'h76);
    steps(8);
    send(0, 0, 'h1A);
    steps(8);
    chk("disc_freq2", u_if.frequencies[2], 75178);
    chk("disc_freq0", u_if.frequencies[0], 106318);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8) c = codes[$urandom_range(0, 23)];
      else c = $urandom_range(0, 255);
      send($urandom_range(0, 99) < 55, $urandom_range(0, 9) == 0, c);
      if ($urandom_range(0, 9) == 0) steps($urandom_range(100, 600));
      else steps($urandom_range(6, 30));
    end

    hit_reset();
    drop_reset();
    steps(3);
    send(1, 0, 'h15);
    steps(5 + 5 * DIV);
    chk("att_freq0", u_if.frequencies[0], 133952);
    hit_reset();
    drop_reset();
    steps(3);
    send(1, 0, 'h1A);
    steps(5);
    chk("rep_freq0", u_if.frequencies[0], 66977);
    chk("rep_vol0", u_if.voice_volumes[0], 0);
    steps(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
